t07_fpu_fixtofloat: RTL and testbench

Converts an unsigned Q9.23 fixed-point magnitude plus a separate sign bit into an IEEE-754 single-precision float. It is the inverse of the FPU float-to-fixed path. It sits at the FPU result stage, where fixed-point ALU results are repacked into float registers. Normalization is iterative, at one left shift per cycle, behind valid/ready handshakes on both sides.

---
 rtl/t07_fpu_pkg.sv | 53 +++++
 rtl/t07_fpu_fixtofloat.sv | 107 ++++++++++
 tb/tb_t07_fpu_fixtofloat.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t07_fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t07_fpu_pkg
// Purpose  : Shared FPU constants and types. Holds the float field layout,
//            the exponent bias and the fixed-to-float converter state encoding.
// Revision : 1.0  initial release
// ============================================================================
package t07_fpu_pkg;

  // IEEE-754 single-precision field widths, shared with the float-to-fixed path
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FLT_W  = SIGN_W + EXP_W + MANT_W;

  // Fixed-point operand: unsigned Q9.23
  localparam int FIX_W     = 32;
  localparam int FRAC_BITS = 23;

  // Exponent bias and the exponent corresponding to a leading one in bit 31.
  // Bit 31 of a Q9.23 word weighs 2^(31-FRAC_BITS) = 2^8, hence BIAS + 8.
  localparam int BIAS     = 127;
  localparam int EXP_INIT = BIAS + (FIX_W - 1 - FRAC_BITS);

  // Number of low shift-register bits dropped when the mantissa is taken
  // from a normalized word (truncation toward zero).
  localparam int DROP_BITS = FIX_W - 1 - MANT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } fix2flt_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
  } float_t;

  // Assemble a float word from its fields
  function automatic float_t pack_float(input logic              sign,
                                        input logic [EXP_W-1:0]  exponent,
                                        input logic [MANT_W-1:0] mantissa);
    float_t f;
    f.sign     = sign;
    f.exponent = exponent;
    f.mantissa = mantissa;
    return f;
  endfunction

endpackage : t07_fpu_pkg
`default_nettype wire

// File: rtl/t07_fpu_fixtofloat.sv
`default_nettype none
// ============================================================================
// Module   : t07_fpu_fixtofloat
// Purpose  : Converts an unsigned Q9.23 magnitude plus sign into an IEEE-754
//            single. Normalizes iteratively (one left shift per cycle) behind
//            valid/ready handshakes; mantissa is truncated toward zero.
// Revision : 1.0  initial release
// ============================================================================
module t07_fpu_fixtofloat
  import t07_fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FIX_W-1:0] in_fixed,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLT_W-1:0] out_float,
  output logic             busy
);

  localparam logic [EXP_W-1:0] C_EXP_INIT = EXP_W'(EXP_INIT);
  localparam logic [EXP_W-1:0] C_EXP_ONE  = EXP_W'(1);

  fix2flt_state_t   state_q, state_d;
  logic [FIX_W-1:0] shreg_q, shreg_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  float_t           out_float_q, out_float_d;

  // State register and datapath flops; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_float_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_float_q <= out_float_d;
    end
  end

  // Next-state and datapath: load on accept, shift until bit 31 is set, pack
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_float_d = out_float_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          shreg_d = in_fixed;
          exp_d   = C_EXP_INIT;
          if (in_fixed == '0) begin
            // Zero has no leading one; emit a signed zero directly
            out_float_d = pack_float(in_sign, '0, '0);
            state_d     = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (shreg_q[FIX_W-1]) begin
          // Hidden bit is bit 31; the next 23 bits form the mantissa,
          // everything below is discarded (round toward zero)
          out_float_d = pack_float(sign_q, exp_q, shreg_q[FIX_W-2:DROP_BITS]);
          state_d     = DONE;
        end else begin
          // Exponent cannot underflow: at most 31 shifts from 135 ends at 104
          shreg_d = shreg_q << 1;
          exp_d   = exp_q - C_EXP_ONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode registered state only, so there is no
  // combinational path from in_valid or out_ready
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_float = out_float_q;

endmodule : t07_fpu_fixtofloat
`default_nettype wire

// File: tb/tb_t07_fpu_fixtofloat.sv
`default_nettype none
// ============================================================================
// Module   : tb_t07_fpu_fixtofloat
// Purpose  : Scoreboard bench for the fixed-to-float converter. A driver
//            pushes expected results; a monitor pops them when out_valid
//            rises and also checks latency, output stability and round-trip.
// Revision : 1.0  initial release
// ============================================================================
module tb_t07_fpu_fixtofloat;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fixed;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        busy;

  t07_fpu_fixtofloat dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fixed  (in_fixed),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fx;
    logic        sg;
    logic [31:0] fl;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          rdy_mode = 0;   // 0 random, otherwise driven by directed code
  logic        held   = 1'b0;
  logic [31:0] hold_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = fx * 2^-23; float exponent = floor(log2(value)) + 127
  function automatic int lead_one(input logic [31:0] x);
    int p = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    return p;
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] x, input logic s);
    int          p;
    logic [31:0] m;
    p = lead_one(x);
    if (p < 0) return {s, 31'b0};
    if (p >= 23) m = x >> (p - 23);
    else         m = x << (23 - p);
    return {s, 8'(127 + p - 23), m[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    if (x == 0) return 1;
    return 2 + 31 - lead_one(x);
  endfunction

  // Independent float-to-fixed: F = {1,mant} * 2^(exp-127)
  function automatic logic [31:0] flt2fix(input logic [31:0] f);
    longint mag;
    int     sh;
    if (f[30:0] == 0) return 32'h0;
    mag = longint'({1'b1, f[22:0]});
    sh  = int'(f[30:23]) - 127;
    if (sh >= 0) mag = mag << sh;
    else         mag = mag >> (-sh);
    return mag[31:0];
  endfunction

  function automatic logic [31:0] trunc_in(input logic [31:0] x);
    int          p;
    logic [31:0] msk;
    p = lead_one(x);
    if (p < 23) return x;
    msk = 32'hFFFF_FFFF << (p - 23);
    return x & msk;
  endfunction

  // Monitor: first cycle of out_valid pops and checks; later cycles check hold
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst) begin
      if (out_valid) begin
        if (!held) begin
          held     = 1'b1;
          hold_val = out_float;
          tests++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %h, expected no output", out_float);
          end else begin
            e   = sb.pop_front();
            lat = cyc - e.acc;
            if (out_float !== e.fl) begin
              errors++;
              $display("FAIL result in=%h s=%0d: got %h, expected %h", e.fx, e.sg, out_float, e.fl);
            end
            tests++;
            if (lat != e.lat) begin
              errors++;
              $display("FAIL latency in=%h: got %0d, expected %0d", e.fx, lat, e.lat);
            end
            tests++;
            if (flt2fix(out_float) !== trunc_in(e.fx)) begin
              errors++;
              $display("FAIL roundtrip in=%h: got %h, expected %h", e.fx, flt2fix(out_float), trunc_in(e.fx));
            end
          end
        end else begin
          tests++;
          if (out_float !== hold_val || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold: got float=%h rdy=%b busy=%b, expected float=%h rdy=0 busy=1",
                     out_float, in_ready, busy, hold_val);
          end
        end
      end else begin
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Random downstream readiness when not under directed control
  always @(negedge clk) begin
    if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] fx, input logic sg,
                      input logic [31:0] fl, input int lat);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      tests++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b, expected 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_fixed = fx;
    in_sign  = sg;
    @(posedge clk);
    e.fx = fx; e.sg = sg; e.fl = fl; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    in_fixed = $urandom;          // later changes must not matter
    in_sign  = 1'($urandom);
  endtask

  task automatic send_rand(input logic [31:0] fx, input logic sg);
    send(fx, sg, ref_float(fx, sg), ref_lat(fx));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (w >= 500) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    int w;
    logic [31:0] x;
    rst = 1'b1; in_valid = 1'b0; in_fixed = '0; in_sign = 1'b0; out_ready = 1'b0;
    rdy_mode = 2;
    #1;
    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy",      {31'b0, busy},      32'd0);
    check("reset_out_float", out_float,          32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed values with literal expectations
    send(32'h0080_0000, 1'b0, 32'h3F80_0000, 10);
    send(32'h0080_0000, 1'b1, 32'hBF80_0000, 10);
    send(32'h0180_0000, 1'b0, 32'h4040_0000, 9);
    send(32'h0040_0000, 1'b0, 32'h3F00_0000, 11);
    send(32'h0000_0001, 1'b0, 32'h3400_0000, 33);
    send(32'hFFFF_FFFF, 1'b0, 32'h43FF_FFFF, 2);
    send(32'h0000_0000, 1'b0, 32'h0000_0000, 1);
    send(32'h0000_0000, 1'b1, 32'h8000_0000, 1);
    wait_drain();

    // Backpressure: hold out_ready low 20 cycles, poke in_valid meanwhile
    out_ready = 1'b0;
    send(32'h0180_0000, 1'b1, 32'hC040_0000, 9);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_fixed = $urandom;
      in_sign  = 1'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    check("bp_valid_held", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {30'b0, in_ready, out_valid}, 32'd2);
    send(32'h0040_0000, 1'b1, 32'hBF00_0000, 11);
    wait_drain();

    // Reset abort mid-normalization
    send(32'h0000_0001, 1'b0, 32'h3400_0000, 33);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready",  {31'b0, in_ready},  32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_out_float", out_float,          32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(32'h0080_0000, 1'b0, 32'h3F80_0000, 10);
    wait_drain();

    // Random inputs across the whole magnitude range, random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) x = 32'h0;
      send_rand(x, 1'($urandom));
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_t07_fpu_fixtofloat
`default_nettype wire
